// File: rtl/rv32_branch_ctrl.sv
// Branch resolution / redirect controller with a 2-bit saturating-counter BHT.
//   clk, rst                     : clock (rising edge), asynchronous active-high reset
//   fetch_pc_i / pred_taken_o    : BHT lookup for the PC in fetch (combinational)
//   ex_*_i                       : resolved branch/jump information from exec
//   flush_o                      : one-cycle kill of younger instructions on mispredict
//   stall_o                      : hold IF/ID/EX while a redirect is outstanding
//   redirect_valid_o/_pc_o/_ready_i : valid/ready redirect handshake to fetch
//   mispredict_cnt_o             : wrapping count of mispredicts since reset
module rv32_branch_ctrl #(
  parameter int unsigned BHT_ENTRIES = 16,
  parameter logic [1:0]  CNT_INIT    = 2'b01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] fetch_pc_i,
  output logic        pred_taken_o,
  input  logic        ex_valid_i,
  input  logic        ex_is_branch_i,
  input  logic        ex_is_jump_i,
  input  logic [31:0] ex_pc_i,
  input  logic [31:0] ex_target_i,
  input  logic        ex_do_branch_i,
  input  logic        ex_pred_taken_i,
  input  logic [31:0] ex_pred_target_i,
  output logic        flush_o,
  output logic        stall_o,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o,
  input  logic        redirect_ready_i,
  output logic [31:0] mispredict_cnt_o
);

  localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);

  typedef enum logic {
    IDLE     = 1'b0,
    REDIRECT = 1'b1
  } state_e;

  state_e      state_q;
  logic        flush_q;
  logic        redirect_valid_q;
  logic [31:0] redirect_pc_q;
  logic [31:0] mispredict_cnt_q;
  logic [1:0]  bht_q [BHT_ENTRIES];

  logic             taken_c;
  logic             resolve_c;
  logic             mispred_c;
  logic [31:0]      next_pc_c;
  logic [IDX_W-1:0] ex_idx_c;
  logic [IDX_W-1:0] fetch_idx_c;
  logic             bht_we_c;
  logic [1:0]       bht_cur_c;
  logic [1:0]       bht_d;

  // Only the word-index bits of the fetch PC address the table.
  logic unused_fetch_bits;
  assign unused_fetch_bits = &{1'b0, fetch_pc_i[31:IDX_W+2], fetch_pc_i[1:0]};

  // Resolution, mispredict detection and BHT next value.
  always_comb begin
    taken_c     = ex_is_jump_i | ex_do_branch_i;
    resolve_c   = ex_valid_i & (ex_is_branch_i | ex_is_jump_i) & (state_q == IDLE);
    mispred_c   = resolve_c &
                  ((taken_c != ex_pred_taken_i) |
                   (taken_c & ex_pred_taken_i & (ex_target_i != ex_pred_target_i)));
    next_pc_c   = taken_c ? ex_target_i : ex_pc_i + 32'd4;
    ex_idx_c    = ex_pc_i[IDX_W+1:2];
    fetch_idx_c = fetch_pc_i[IDX_W+1:2];
    // Jumps never train the predictor.
    bht_we_c    = resolve_c & ex_is_branch_i;
    bht_cur_c   = bht_q[ex_idx_c];
    bht_d       = bht_cur_c;
    if (taken_c) begin
      if (bht_cur_c != 2'b11) bht_d = bht_cur_c + 2'd1;
    end else begin
      if (bht_cur_c != 2'b00) bht_d = bht_cur_c - 2'd1;
    end
  end

  // Redirect FSM, mispredict counter and BHT storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= IDLE;
      flush_q          <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= 32'd0;
      mispredict_cnt_q <= 32'd0;
      for (int i = 0; i < int'(BHT_ENTRIES); i++) begin
        bht_q[i] <= CNT_INIT;
      end
    end else begin
      // Flush only in the first REDIRECT cycle.
      flush_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (mispred_c) begin
            state_q          <= REDIRECT;
            redirect_pc_q    <= next_pc_c;
            redirect_valid_q <= 1'b1;
            flush_q          <= 1'b1;
            mispredict_cnt_q <= mispredict_cnt_q + 32'd1;
          end
        end
        REDIRECT: begin
          if (redirect_ready_i) begin
            state_q          <= IDLE;
            redirect_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q          <= IDLE;
          redirect_valid_q <= 1'b0;
        end
      endcase
      if (bht_we_c) begin
        bht_q[ex_idx_c] <= bht_d;
      end
    end
  end

  // Read returns the pre-update value when fetch and exec hit the same entry.
  assign pred_taken_o     = bht_q[fetch_idx_c][1];
  assign stall_o          = (state_q == REDIRECT);
  assign flush_o          = flush_q;
  assign redirect_valid_o = redirect_valid_q;
  assign redirect_pc_o    = redirect_pc_q;
  assign mispredict_cnt_o = mispredict_cnt_q;

endmodule

// File: tb/tb_rv32_branch_ctrl.sv
// Directed self-checking bench for rv32_branch_ctrl.
module tb_rv32_branch_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] fetch_pc_i;
  logic        pred_taken_o;
  logic        ex_valid_i;
  logic        ex_is_branch_i;
  logic        ex_is_jump_i;
  logic [31:0] ex_pc_i;
  logic [31:0] ex_target_i;
  logic        ex_do_branch_i;
  logic        ex_pred_taken_i;
  logic [31:0] ex_pred_target_i;
  logic        flush_o;
  logic        stall_o;
  logic        redirect_valid_o;
  logic [31:0] redirect_pc_o;
  logic        redirect_ready_i;
  logic [31:0] mispredict_cnt_o;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  rv32_branch_ctrl #(.BHT_ENTRIES(16), .CNT_INIT(2'b01)) dut (
    .clk              (clk),
    .rst              (rst),
    .fetch_pc_i       (fetch_pc_i),
    .pred_taken_o     (pred_taken_o),
    .ex_valid_i       (ex_valid_i),
    .ex_is_branch_i   (ex_is_branch_i),
    .ex_is_jump_i     (ex_is_jump_i),
    .ex_pc_i          (ex_pc_i),
    .ex_target_i      (ex_target_i),
    .ex_do_branch_i   (ex_do_branch_i),
    .ex_pred_taken_i  (ex_pred_taken_i),
    .ex_pred_target_i (ex_pred_target_i),
    .flush_o          (flush_o),
    .stall_o          (stall_o),
    .redirect_valid_o (redirect_valid_o),
    .redirect_pc_o    (redirect_pc_o),
    .redirect_ready_i (redirect_ready_i),
    .mispredict_cnt_o (mispredict_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ex_clear();
    ex_valid_i       = 1'b0;
    ex_is_branch_i   = 1'b0;
    ex_is_jump_i     = 1'b0;
    ex_pc_i          = 32'd0;
    ex_target_i      = 32'd0;
    ex_do_branch_i   = 1'b0;
    ex_pred_taken_i  = 1'b0;
    ex_pred_target_i = 32'd0;
  endtask

  // Present one exec instruction for one cycle; outputs sampled 1 time unit after the edge.
  task automatic exec(input logic vld, input logic br, input logic jp, input logic [31:0] pc,
                      input logic [31:0] tgt, input logic dob, input logic ptk,
                      input logic [31:0] ptgt);
    ex_valid_i       = vld;
    ex_is_branch_i   = br;
    ex_is_jump_i     = jp;
    ex_pc_i          = pc;
    ex_target_i      = tgt;
    ex_do_branch_i   = dob;
    ex_pred_taken_i  = ptk;
    ex_pred_target_i = ptgt;
    tick();
    ex_clear();
  endtask

  task automatic pred_at(input string tag, input logic [31:0] pc, input logic exp);
    fetch_pc_i = pc;
    #1;
    chk(tag, 32'(pred_taken_o), 32'(exp));
  endtask

  initial begin
    rst = 1'b1;
    fetch_pc_i = 32'd0;
    redirect_ready_i = 1'b0;
    ex_clear();
    #2;

    // T1: reset state
    for (int a = 0; a <= 32'h3C; a += 4) pred_at("t1_pred_init", 32'(a), 1'b0);
    chk("t1_valid", 32'(redirect_valid_o), 32'd0);
    chk("t1_flush", 32'(flush_o), 32'd0);
    chk("t1_stall", 32'(stall_o), 32'd0);
    chk("t1_rpc",   redirect_pc_o, 32'd0);
    chk("t1_cnt",   mispredict_cnt_o, 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // T2: taken branch predicted not-taken, fetch accepts after 4 REDIRECT cycles
    exec(1'b1, 1'b1, 1'b0, 32'h100, 32'h80, 1'b1, 1'b0, 32'h0);
    chk("t2_flush_c1", 32'(flush_o), 32'd1);
    chk("t2_valid_c1", 32'(redirect_valid_o), 32'd1);
    chk("t2_rpc_c1",   redirect_pc_o, 32'h80);
    chk("t2_stall_c1", 32'(stall_o), 32'd1);
    chk("t2_cnt",      mispredict_cnt_o, 32'd1);
    tick();
    chk("t2_flush_c2", 32'(flush_o), 32'd0);
    chk("t2_stall_c2", 32'(stall_o), 32'd1);
    chk("t2_rpc_c2",   redirect_pc_o, 32'h80);
    tick();
    chk("t2_stall_c3", 32'(stall_o), 32'd1);
    tick();
    chk("t2_stall_c4", 32'(stall_o), 32'd1);
    chk("t2_valid_c4", 32'(redirect_valid_o), 32'd1);
    redirect_ready_i = 1'b1;
    tick();
    redirect_ready_i = 1'b0;
    chk("t2_stall_done", 32'(stall_o), 32'd0);
    chk("t2_valid_done", 32'(redirect_valid_o), 32'd0);
    chk("t2_cnt_done",   mispredict_cnt_o, 32'd1);

    // T3: predicted taken, actually not-taken -> fall-through; ready already high
    redirect_ready_i = 1'b1;
    exec(1'b1, 1'b1, 1'b0, 32'h200, 32'h210, 1'b0, 1'b1, 32'h210);
    chk("t3_rpc",   redirect_pc_o, 32'h204);
    chk("t3_valid", 32'(redirect_valid_o), 32'd1);
    chk("t3_cnt",   mispredict_cnt_o, 32'd2);
    tick();
    chk("t3_stall_1cyc", 32'(stall_o), 32'd0);
    chk("t3_valid_1cyc", 32'(redirect_valid_o), 32'd0);
    tick();
    chk("t3_ready_idle_ignored", 32'(redirect_valid_o), 32'd0);
    redirect_ready_i = 1'b0;

    // Fresh BHT for training
    rst = 1'b1;
    #1;
    chk("rst_cnt", mispredict_cnt_o, 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // T4: train index 0 (pc 0x40); correct predictions so no redirects
    pred_at("t4_init", 32'h40, 1'b0);
    exec(1'b1, 1'b1, 1'b0, 32'h40, 32'h20, 1'b1, 1'b1, 32'h20);
    pred_at("t4_after1t", 32'h40, 1'b1);
    chk("t4_no_redir", 32'(redirect_valid_o), 32'd0);
    for (int k = 0; k < 3; k++) exec(1'b1, 1'b1, 1'b0, 32'h40, 32'h20, 1'b1, 1'b1, 32'h20);
    exec(1'b1, 1'b1, 1'b0, 32'h40, 32'h20, 1'b0, 1'b0, 32'h0);
    pred_at("t4_sat_then_nt", 32'h40, 1'b1);
    exec(1'b1, 1'b1, 1'b0, 32'h40, 32'h20, 1'b0, 1'b0, 32'h0);
    pred_at("t4_cnt1", 32'h40, 1'b0);
    exec(1'b1, 1'b1, 1'b0, 32'h40, 32'h20, 1'b0, 1'b0, 32'h0);
    pred_at("t4_cnt0", 32'h40, 1'b0);
    chk("t4_no_mispred", mispredict_cnt_o, 32'd0);
    // counter 00 -> 01 via alias 0x80, -> 10 via 0x40
    exec(1'b1, 1'b1, 1'b0, 32'h80, 32'h20, 1'b1, 1'b1, 32'h20);
    pred_at("t4_alias_01", 32'h40, 1'b0);
    exec(1'b1, 1'b1, 1'b0, 32'h40, 32'h20, 1'b1, 1'b1, 32'h20);
    pred_at("t4_alias_80", 32'h80, 1'b1);
    pred_at("t4_other_idx", 32'h44, 1'b0);
    // same-cycle read/write shows the pre-update value (10 -> 01)
    fetch_pc_i       = 32'h40;
    ex_valid_i       = 1'b1;
    ex_is_branch_i   = 1'b1;
    ex_pc_i          = 32'h40;
    ex_target_i      = 32'h20;
    ex_do_branch_i   = 1'b0;
    ex_pred_taken_i  = 1'b0;
    @(negedge clk);
    chk("t4_rw_pre", 32'(pred_taken_o), 32'd1);
    tick();
    ex_clear();
    chk("t4_rw_post", 32'(pred_taken_o), 32'd0);

    // T5: jumps (index 0 counter is 01)
    exec(1'b1, 1'b0, 1'b1, 32'h300, 32'h500, 1'b0, 1'b1, 32'h500);
    chk("t5_jmp_ok_noredir", 32'(redirect_valid_o), 32'd0);
    pred_at("t5_jmp_no_train", 32'h300, 1'b0);
    exec(1'b0, 1'b1, 1'b0, 32'h40, 32'h20, 1'b1, 1'b0, 32'h0);
    chk("t5_invalid_ignored", 32'(redirect_valid_o), 32'd0);
    exec(1'b1, 1'b0, 1'b1, 32'h300, 32'h500, 1'b0, 1'b1, 32'h504);
    chk("t5_jmp_bad_valid", 32'(redirect_valid_o), 32'd1);
    chk("t5_jmp_bad_rpc",   redirect_pc_o, 32'h500);
    chk("t5_jmp_bad_flush", 32'(flush_o), 32'd1);
    chk("t5_cnt",           mispredict_cnt_o, 32'd1);

    // T6: exec ignored during REDIRECT; reset drops the request immediately
    exec(1'b1, 1'b1, 1'b0, 32'h40, 32'h700, 1'b1, 1'b0, 32'h0);
    chk("t6_cnt_held", mispredict_cnt_o, 32'd1);
    chk("t6_rpc_held", redirect_pc_o, 32'h500);
    chk("t6_flush_low", 32'(flush_o), 32'd0);
    pred_at("t6_bht_held", 32'h40, 1'b0);
    chk("t6_still_stall", 32'(stall_o), 32'd1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", 32'(redirect_valid_o), 32'd0);
    chk("t6_rst_stall", 32'(stall_o), 32'd0);
    chk("t6_rst_rpc",   redirect_pc_o, 32'd0);
    tick();
    rst = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
